// File: rtl/adc_delay_pkg.sv
`timescale 1ns/1ps
// Shared constants for the ADC tap-delay optimisation slice: default widths, training word,
// one-hot state encoding and the command code that launches an optimisation.
package adc_delay_pkg;

    localparam int DEF_TAP_W  = 5;
    localparam int DEF_NTAPS  = 32;
    localparam int DEF_DATA_W = 14;

    localparam logic [DEF_DATA_W-1:0] DEF_TRAIN_PATTERN = 14'h2A5C;

    // Command code the CC_OPT_DELAY handler decodes before raising start_opt.
    localparam logic [7:0] CC_OPT_DELAY = 8'h21;

    localparam int ST_IDLE     = 0;
    localparam int ST_LOAD_TAP = 1;
    localparam int ST_SETTLE   = 2;
    localparam int ST_SAMPLE   = 3;
    localparam int ST_EVAL     = 4;
    localparam int ST_APPLY    = 5;
    localparam int ST_DONE     = 6;
    localparam int ST_RESTORE  = 7;
    localparam int N_STATES    = 8;

    typedef enum logic [N_STATES-1:0] {
        IDLE     = 8'b0000_0001,
        LOAD_TAP = 8'b0000_0010,
        SETTLE   = 8'b0000_0100,
        SAMPLE   = 8'b0000_1000,
        EVAL     = 8'b0001_0000,
        APPLY    = 8'b0010_0000,
        DONE     = 8'b0100_0000,
        RESTORE  = 8'b1000_0000
    } state_e;

endpackage

// File: rtl/adc_tap_opt_ctrl_if.sv
`timescale 1ns/1ps
// Command handshake, ADC data and IDELAY control bundle for one channel.
interface adc_tap_opt_ctrl_if
    import adc_delay_pkg::*;
#(
    parameter int TAP_W  = DEF_TAP_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              start_opt;
    logic              opt_done;
    logic              opt_error;
    logic              busy;
    logic [DATA_W-1:0] adc_data;
    logic [TAP_W-1:0]  delay_tap;
    logic              delay_ld;
    logic [TAP_W-1:0]  opt_tap;
    logic [TAP_W:0]    win_len;

    modport master (
        output start_opt, adc_data,
        input  opt_done, opt_error, busy, delay_tap, delay_ld, opt_tap, win_len
    );

    modport slave (
        input  start_opt, adc_data,
        output opt_done, opt_error, busy, delay_tap, delay_ld, opt_tap, win_len
    );
endinterface

// File: rtl/tap_window_tracker.sv
`timescale 1ns/1ps
// Tracks the current and best contiguous run of clean taps and derives the centre
// of the best run; ties keep the earliest run.
module tap_window_tracker
    import adc_delay_pkg::*;
#(
    parameter int TAP_W = DEF_TAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             eval,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] centre
);
    logic [TAP_W:0]   cur_len;
    logic [TAP_W:0]   len_inc;
    logic [TAP_W-1:0] cur_start;
    logic [TAP_W-1:0] run_start;

    assign len_inc   = cur_len + (TAP_W+1)'(1);
    assign run_start = (cur_len == '0) ? tap : cur_start;
    assign centre    = TAP_W'({1'b0, best_start} + ((best_len - (TAP_W+1)'(1)) >> 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_len    <= '0;
            cur_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (clear) begin
            cur_len    <= '0;
            cur_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (eval) begin
            if (pass) begin
                cur_len   <= len_inc;
                cur_start <= run_start;
                if (len_inc > best_len) begin
                    best_len   <= len_inc;
                    best_start <= run_start;
                end
            end else begin
                cur_len <= '0;
            end
        end
    end
endmodule

// File: rtl/adc_tap_opt_ctrl.sv
`timescale 1ns/1ps
// Scans every IDELAY tap against the training word, then loads the centre of the longest
// clean run; an abort reloads the last good tap.
module adc_tap_opt_ctrl
    import adc_delay_pkg::*;
#(
    parameter int                NTAPS         = DEF_NTAPS,
    parameter int                TAP_W         = DEF_TAP_W,
    parameter int                DATA_W        = DEF_DATA_W,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                SETTLE_CYC    = 16,
    parameter int                SAMPLE_CYC    = 64,
    parameter int                MIN_WINDOW    = 4,
    parameter int                DEFAULT_TAP   = 16
) (
    input  logic                clk,
    input  logic                reset,
    adc_tap_opt_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(SETTLE_CYC + SAMPLE_CYC);

    state_e            state, state_nxt;
    logic [TAP_W-1:0]  tap;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              mismatch;
    logic              err_flag;
    logic [TAP_W-1:0]  opt_tap_q;
    logic [TAP_W-1:0]  held_tap;
    logic [TAP_W:0]    win_len_q;
    logic [TAP_W-1:0]  delay_tap_c;
    logic              delay_ld_c;
    logic [TAP_W-1:0]  best_start;
    logic [TAP_W:0]    best_len;
    logic [TAP_W-1:0]  centre;
    logic              tap_last;
    logic              window_ok;
    logic [TAP_W-1:0]  apply_tap;

    assign tap_last  = (tap == TAP_W'(NTAPS - 1));
    assign window_ok = (best_len >= (TAP_W+1)'(MIN_WINDOW));
    assign apply_tap = window_ok ? centre : opt_tap_q;

    tap_window_tracker #(.TAP_W(TAP_W)) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (state[ST_IDLE] && bus.start_opt),
        .eval       (state[ST_EVAL]),
        .pass       (!mismatch),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len),
        .centre     (centre)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        delay_ld_c  = 1'b0;
        delay_tap_c = held_tap;
        unique case (state)
            IDLE:     if (bus.start_opt) state_nxt = LOAD_TAP;
            LOAD_TAP: begin
                delay_ld_c  = 1'b1;
                delay_tap_c = tap;
                state_nxt   = bus.start_opt ? SETTLE : RESTORE;
            end
            SETTLE: begin
                if (!bus.start_opt)                           state_nxt = RESTORE;
                else if (cyc_cnt == CNT_W'(SETTLE_CYC - 1))   state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (!bus.start_opt)                           state_nxt = RESTORE;
                else if (cyc_cnt == CNT_W'(SAMPLE_CYC - 1))   state_nxt = EVAL;
            end
            EVAL: begin
                if (!bus.start_opt) state_nxt = RESTORE;
                else if (tap_last)  state_nxt = APPLY;
                else                state_nxt = LOAD_TAP;
            end
            APPLY: begin
                delay_ld_c  = 1'b1;
                delay_tap_c = apply_tap;
                state_nxt   = bus.start_opt ? DONE : RESTORE;
            end
            DONE:     if (!bus.start_opt) state_nxt = IDLE;
            RESTORE: begin
                delay_ld_c  = 1'b1;
                delay_tap_c = opt_tap_q;
                state_nxt   = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tap       <= '0;
            cyc_cnt   <= '0;
            mismatch  <= 1'b0;
            err_flag  <= 1'b0;
            opt_tap_q <= TAP_W'(DEFAULT_TAP);
            held_tap  <= TAP_W'(DEFAULT_TAP);
            win_len_q <= '0;
        end else begin
            state    <= state_nxt;
            held_tap <= delay_tap_c;
            cyc_cnt  <= (state_nxt != state) ? '0 : cyc_cnt + CNT_W'(1);
            if (state[ST_IDLE] && bus.start_opt) begin
                tap      <= '0;
                mismatch <= 1'b0;
            end
            if (state[ST_SAMPLE] && (bus.adc_data != TRAIN_PATTERN)) mismatch <= 1'b1;
            if (state[ST_EVAL]) begin
                mismatch <= 1'b0;
                if (!tap_last) tap <= tap + TAP_W'(1);
            end
            if (state[ST_APPLY]) begin
                win_len_q <= best_len;
                opt_tap_q <= apply_tap;
                err_flag  <= !window_ok;
            end
        end
    end

    assign bus.busy      = !state[ST_IDLE];
    assign bus.opt_done  = state[ST_DONE];
    assign bus.opt_error = state[ST_DONE] && err_flag;
    assign bus.delay_ld  = delay_ld_c;
    assign bus.delay_tap = delay_tap_c;
    assign bus.opt_tap   = opt_tap_q;
    assign bus.win_len   = win_len_q;
endmodule
